coherence_bus_arbiter: RTL and testbench
========================================

// Module: coherence_bus_arbiter
// PURPOSE
//  Parametrised memory/coherence controller for CPUS cores sharing one RAM port.
//  Round-robin arbitration of data transactions, snoop broadcast to all non-owning caches,
//  cache-to-cache forwarding with concurrent writeback, and multi-word block transfers.
//  Sits between per-core L1 I/D caches and the single-ported RAM model.
//  Instruction fetches are served only when no data transaction is in progress.
// PARAMETERS
//  CPUS           2    number of cores (2..8); GW = $clog2(CPUS) grant-index width
//  BLOCK_WORDS    2    words per cache-block transfer (power of 2, 1..8)
//  SNOOP_TIMEOUT  16   max SNOOP cycles before falling back to MEM
// PORTS
//  CLK          in   1          clock
//  nRST         in   1          asynchronous active-low reset
//  iREN         in   CPUS       instruction read request, per core
//  iaddr        in   CPUS x 32  instruction address
//  iwait        out  CPUS       1 = instruction not ready
//  iload        out  CPUS x 32  instruction data
//  dREN/dWEN    in   CPUS       data read / writeback request
//  daddr/dstore in   CPUS x 32  data address / write data
//  dwait        out  CPUS       1 = data word not done
//  dload        out  CPUS x 32  data load
//  ccwrite      in   CPUS       owner: write intent; snooped core: holds dirty copy
//  cctrans      in   CPUS       snooped core still resolving its snoop
//  ccwait       out  CPUS       1 = core stalled by a coherence operation
//  ccinv        out  CPUS       invalidate the line at ccsnoopaddr
//  ccsnoopaddr  out  CPUS x 32  snoop address, per core
//  ramREN/ramWEN out 1          RAM read / write strobes
//  ramaddr/ramstore out 32      RAM address / write data
//  ramload      in   32         RAM read data
//  ramstate     in   ramstate_t FREE/BUSY/ACCESS/ERROR
//  snoop_err    out  1          one-cycle pulse on SNOOP timeout
// BEHAVIOUR
//  Reset: state IDLE; waits all 1; ccwait, ccinv, ramREN, ramWEN, snoop_err 0;
//   loads, snoopaddr, ramaddr, ramstore 0; rr pointers CPUS-1 (core 0 wins first).
//  FSM (registered grant g, supplier s, word counter wc, timeout counter tc):
//   IDLE:  if any dREN|dWEN -> ARB. Else serve round-robin iREN winner k: ramREN=1,
//          ramaddr=iaddr[k]; iload[k] driven combinationally from ramload;
//          iwait[k]=(ramstate!=ACCESS). The I-pointer advances to k on ACCESS.
//   ARB:   ccwait all 1. Latch g = data rr winner; wc=0; tc=0. -> SNOOP.
//   SNOOP: ccwait[g]=0, others 1. ccsnoopaddr[j]=daddr[g] and ccinv[j]=ccwrite[g], for j!=g.
//          Wait while any cctrans[j!=g]. Then if any ccwrite[j!=g], latch lowest such j into s
//          and go -> C2C; else go -> MEM. If tc reaches SNOOP_TIMEOUT: pulse snoop_err, -> MEM.
//   C2C:   dload[g]=dstore[s]. Writeback on the RAM port: ramWEN=1, ramaddr=daddr[s], ramstore=dstore[s].
//          dwait[g]=dwait[s]=(ramstate!=ACCESS). ccwait[s]=1.
//   MEM:   ramREN=dREN[g], ramWEN=dWEN[g], ramaddr=daddr[g], ramstore=dstore[g];
//          dload[g] driven from ramload; dwait[g]=(ramstate!=ACCESS). ccwait on others is 0.
//  In C2C and MEM, wc increments on each ACCESS. In the cycle of ACCESS with wc==BLOCK_WORDS-1:
//   go -> IDLE and set the data rr pointer to g.
//  Requester drops dREN|dWEN in C2C or MEM: abort to IDLE next cycle; the pointer is still set to g.
//  ramstate ERROR is treated as not-ACCESS; the controller keeps waiting.
//  Simultaneous requests: only one data owner at a time. Later requesters keep dwait=1.
//  wc wraps via modulo BLOCK_WORDS. Reset asserted mid-transaction returns to the reset state.
// STRUCTURE
//  cpu_types_pkg: add bus_state_t {IDLE,ARB,SNOOP,C2C,MEM}; reuse word_t and ramstate_t.
//  Sub-module rr_arbiter #(N): req[N], ptr[GW], advance, win index, win_valid.
//   Instantiated twice: instruction and data.
//  All output logic sits in one always_comb with defaults assigned first (no latches).
// TESTING
//  1 CPUS=2: iREN on both, ACCESS every 2nd cycle -> core0 then core1 alternate, one word each.
//  2 CPUS=4: dREN on cores 1 and 3 at t0 -> core1 granted first, then core3.
//    No other core's dwait drops while core1 holds the grant.
//  3 Owner 0 reads 0x100 and core 2 snoops dirty (ccwrite[2]=1) -> C2C.
//    dload[0]==dstore[2]; ramWEN=1; ramaddr=0x100; 2 words; then IDLE.
//  4 Owner 1 writes with ccwrite[1]=1 -> ccinv[j]=1 for all j!=1 during SNOOP, then MEM, 2 writes.
//  5 cctrans[1] stuck high -> snoop_err pulses after 16 SNOOP cycles; MEM completes.
//  6 nRST low during MEM word 1 -> all outputs at reset values; next dREN from core 0 wins.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM side of the CPU: word type, RAM handshake state
// and the coherence bus controller's state encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    SNOOP = 3'd2,
    C2C   = 3'd3,
    MEM   = 3'd4
  } bus_state_t;

endpackage

// File: rtl/coherence_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester strictly after ptr_i wins,
// so the last-served index ends up with the lowest priority.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  output logic [GW-1:0] win_o,
  output logic          win_valid_o
);

  int            k;
  logic [GW-1:0] sel;

  always_comb begin
    win_o       = '0;
    win_valid_o = 1'b0;
    k           = 0;
    sel         = '0;
    for (int i = 1; i <= N; i++) begin
      k = int'(ptr_i) + i;
      if (k >= N) k = k - N;
      sel = GW'(k);
      if (!win_valid_o && req_i[sel]) begin
        win_valid_o = 1'b1;
        win_o       = sel;
      end
    end
  end

endmodule

// File: rtl/coherence_bus_arbiter.sv
// Shared-RAM coherence controller: round-robin data ownership, snoop broadcast,
// cache-to-cache forwarding with writeback, block transfers; I-fetch only when idle.
module coherence_bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS          = 2,
  parameter int BLOCK_WORDS   = 2,
  parameter int SNOOP_TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic [CPUS-1:0]       iREN,
  input  word_t [CPUS-1:0]      iaddr,
  output logic [CPUS-1:0]       iwait,
  output word_t [CPUS-1:0]      iload,
  input  logic [CPUS-1:0]       dREN,
  input  logic [CPUS-1:0]       dWEN,
  input  word_t [CPUS-1:0]      daddr,
  input  word_t [CPUS-1:0]      dstore,
  output logic [CPUS-1:0]       dwait,
  output word_t [CPUS-1:0]      dload,
  input  logic [CPUS-1:0]       ccwrite,
  input  logic [CPUS-1:0]       cctrans,
  output logic [CPUS-1:0]       ccwait,
  output logic [CPUS-1:0]       ccinv,
  output word_t [CPUS-1:0]      ccsnoopaddr,
  output logic                  ramREN,
  output logic                  ramWEN,
  output word_t                 ramaddr,
  output word_t                 ramstore,
  input  word_t                 ramload,
  input  ramstate_t             ramstate,
  output logic                  snoop_err
);

  localparam int GW  = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam int TCW = $clog2(SNOOP_TIMEOUT + 1);

  bus_state_t     state_q, state_d;
  logic [GW-1:0]  g_q, g_d, s_q, s_d;
  logic [GW-1:0]  iptr_q, iptr_d, dptr_q, dptr_d;
  logic [WCW-1:0] wc_q, wc_d;
  logic [TCW-1:0] tc_q, tc_d;

  logic [GW-1:0]   i_win, d_win;
  logic            i_vld, d_vld;
  logic            acc, req_g;
  logic [CPUS-1:0] oth_write, oth_trans;

  rr_arbiter #(.N(CPUS), .GW(GW)) u_iarb (
    .req_i       (iREN),
    .ptr_i       (iptr_q),
    .win_o       (i_win),
    .win_valid_o (i_vld)
  );

  rr_arbiter #(.N(CPUS), .GW(GW)) u_darb (
    .req_i       (dREN | dWEN),
    .ptr_i       (dptr_q),
    .win_o       (d_win),
    .win_valid_o (d_vld)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      g_q     <= '0;
      s_q     <= '0;
      wc_q    <= '0;
      tc_q    <= '0;
      iptr_q  <= GW'(CPUS - 1);
      dptr_q  <= GW'(CPUS - 1);
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      s_q     <= s_d;
      wc_q    <= wc_d;
      tc_q    <= tc_d;
      iptr_q  <= iptr_d;
      dptr_q  <= dptr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    s_d         = s_q;
    wc_d        = wc_q;
    tc_d        = tc_q;
    iptr_d      = iptr_q;
    dptr_d      = dptr_q;
    iwait       = '1;
    iload       = '0;
    dwait       = '1;
    dload       = '0;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    snoop_err   = 1'b0;
    // ERROR falls through as not-ACCESS, so the requester simply keeps waiting
    acc         = (ramstate == ACCESS);
    req_g       = dREN[g_q] | dWEN[g_q];
    oth_write   = ccwrite;
    oth_write[g_q] = 1'b0;
    oth_trans   = cctrans;
    oth_trans[g_q] = 1'b0;

    if (nRST) begin
      unique case (state_q)
        IDLE: begin
          if (|(dREN | dWEN)) begin
            state_d = ARB;
          end else if (i_vld) begin
            ramREN       = 1'b1;
            ramaddr      = iaddr[i_win];
            iload[i_win] = ramload;
            iwait[i_win] = !acc;
            if (acc) iptr_d = i_win;
          end
        end
        ARB: begin
          ccwait = '1;
          if (d_vld) begin
            g_d     = d_win;
            wc_d    = '0;
            tc_d    = '0;
            state_d = SNOOP;
          end else begin
            state_d = IDLE;
          end
        end
        SNOOP: begin
          ccwait      = '1;
          ccwait[g_q] = 1'b0;
          for (int j = 0; j < CPUS; j++) begin
            if (GW'(j) != g_q) begin
              ccsnoopaddr[j] = daddr[g_q];
              ccinv[j]       = ccwrite[g_q];
            end
          end
          if (|oth_trans) begin
            if (tc_q == TCW'(SNOOP_TIMEOUT - 1)) begin
              snoop_err = 1'b1;
              state_d   = MEM;
            end else begin
              tc_d = tc_q + 1'b1;
            end
          end else if (|oth_write) begin
            // descending scan leaves the lowest dirty holder as supplier
            for (int j = CPUS - 1; j >= 0; j--) begin
              if (oth_write[j]) s_d = GW'(j);
            end
            state_d = C2C;
          end else begin
            state_d = MEM;
          end
        end
        C2C, MEM: begin
          if (!req_g) begin
            state_d = IDLE;
            dptr_d  = g_q;
          end else begin
            if (state_q == C2C) begin
              ccwait[s_q] = 1'b1;
              dload[g_q]  = dstore[s_q];
              ramWEN      = 1'b1;
              ramaddr     = daddr[s_q];
              ramstore    = dstore[s_q];
              dwait[s_q]  = !acc;
            end else begin
              dload[g_q]  = ramload;
              ramREN      = dREN[g_q];
              ramWEN      = dWEN[g_q];
              ramaddr     = daddr[g_q];
              ramstore    = dstore[g_q];
            end
            dwait[g_q] = !acc;
            if (acc) begin
              if (wc_q == WCW'(BLOCK_WORDS - 1)) begin
                wc_d    = '0;
                state_d = IDLE;
                dptr_d  = g_q;
              end else begin
                wc_d = wc_q + 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter with four cores and two-word blocks.
module tb_coherence_bus_arbiter;
  import cpu_types_pkg::*;

  localparam int CPUS = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic [CPUS-1:0]   iREN, dREN, dWEN, ccwrite, cctrans;
  word_t [CPUS-1:0]  iaddr, daddr, dstore;
  logic [CPUS-1:0]   iwait, dwait, ccwait, ccinv;
  word_t [CPUS-1:0]  iload, dload, ccsnoopaddr;
  logic              ramREN, ramWEN, snoop_err;
  word_t             ramaddr, ramstore, ramload;
  ramstate_t         ramstate;

  int total = 0;
  int bad   = 0;
  int n, errcyc;

  coherence_bus_arbiter #(.CPUS(CPUS), .BLOCK_WORDS(2), .SNOOP_TIMEOUT(16)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ccwrite(ccwrite), .cctrans(cctrans), .ccwait(ccwait), .ccinv(ccinv),
    .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .snoop_err(snoop_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  initial begin
    nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
    tick();
    chk("rst_iwait", iwait, 4'hF);
    chk("rst_dwait", dwait, 4'hF);
    chk("rst_ccwait", ccwait, 4'h0);
    chk("rst_ccinv", ccinv, 4'h0);
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramWEN", ramWEN, 1'b0);
    chk("rst_snoop_err", snoop_err, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    tick();
    nRST = 1'b1;

    // instruction fetch alternation, ACCESS every second cycle
    iREN = 4'b0011; iaddr[0] = 32'h1000; iaddr[1] = 32'h2000; ramstate = BUSY; #1;
    chk("if_ren", ramREN, 1'b1);
    chk("if_addr0", ramaddr, 32'h1000);
    chk("if_wait_busy", iwait, 4'hF);
    tick(); ramstate = ACCESS; ramload = 32'h1111_0000; #1;
    chk("if_wait0", iwait, 4'b1110);
    chk("if_load0", iload[0], 32'h1111_0000);
    tick(); ramstate = BUSY; #1;
    chk("if_addr1", ramaddr, 32'h2000);
    chk("if_wait_busy1", iwait, 4'hF);
    tick(); ramstate = ACCESS; ramload = 32'h2222_0000; #1;
    chk("if_wait1", iwait, 4'b1101);
    chk("if_load1", iload[1], 32'h2222_0000);
    tick(); ramstate = BUSY; #1;
    chk("if_back0", ramaddr, 32'h1000);
    iREN = '0; ramstate = FREE;

    // two data requesters: core 1 then core 3
    tick(); dREN = 4'b1010; daddr[1] = 32'h300; daddr[3] = 32'h400; #1;
    chk("d_idle_wait", dwait, 4'hF);
    chk("d_idle_ren", ramREN, 1'b0);
    tick();
    chk("arb_ccwait", ccwait, 4'hF);
    tick();
    chk("snp1_ccwait", ccwait, 4'b1101);
    chk("snp1_addr0", ccsnoopaddr[0], 32'h300);
    chk("snp1_addr_own", ccsnoopaddr[1], 32'h0);
    chk("snp1_inv", ccinv, 4'h0);
    tick(); ramstate = ERROR; #1;
    chk("mem1_ren", ramREN, 1'b1);
    chk("mem1_addr", ramaddr, 32'h300);
    chk("mem1_err_wait", dwait, 4'hF);
    chk("mem1_ccwait", ccwait, 4'h0);
    tick(); ramstate = ACCESS; ramload = 32'h5; #1;
    chk("mem1_w0_wait", dwait, 4'b1101);
    chk("mem1_w0_load", dload[1], 32'h5);
    tick(); ramload = 32'h6; #1;
    chk("mem1_w1_wait", dwait, 4'b1101);
    chk("mem1_w1_load", dload[1], 32'h6);
    tick(); dREN = 4'b1000; ramstate = FREE; #1;
    chk("idle2_wait", dwait, 4'hF);
    tick();
    tick();
    chk("snp3_ccwait", ccwait, 4'b0111);
    chk("snp3_addr0", ccsnoopaddr[0], 32'h400);
    tick(); ramstate = ACCESS; ramload = 32'h7; #1;
    chk("mem3_addr", ramaddr, 32'h400);
    chk("mem3_w0_load", dload[3], 32'h7);
    chk("mem3_w0_wait", dwait, 4'b0111);
    tick(); ramload = 32'h8; #1;
    chk("mem3_w1_load", dload[3], 32'h8);
    tick(); dREN = '0; ramstate = FREE; #1;
    chk("idle3_wait", dwait, 4'hF);

    // cache-to-cache: owner 0 reads, core 2 dirty
    tick(); dREN = 4'b0001; daddr[0] = 32'h100; daddr[2] = 32'h100;
    dstore[2] = 32'hD00D_0001; ccwrite = 4'b0100; #1;
    chk("c2c_idle_ccwait", ccwait, 4'h0);
    tick();
    tick();
    chk("c2c_snp_ccwait", ccwait, 4'b1110);
    chk("c2c_snp_inv", ccinv, 4'h0);
    chk("c2c_snp_addr2", ccsnoopaddr[2], 32'h100);
    tick(); ramstate = BUSY; #1;
    chk("c2c_wen", ramWEN, 1'b1);
    chk("c2c_ren", ramREN, 1'b0);
    chk("c2c_addr", ramaddr, 32'h100);
    chk("c2c_store", ramstore, 32'hD00D_0001);
    chk("c2c_load", dload[0], 32'hD00D_0001);
    chk("c2c_busy_wait", dwait, 4'hF);
    chk("c2c_ccwait", ccwait, 4'b0100);
    tick(); ramstate = ACCESS; dstore[2] = 32'hD00D_0002; #1;
    chk("c2c_w0_load", dload[0], 32'hD00D_0002);
    chk("c2c_w0_wait", dwait, 4'b1010);
    tick();
    chk("c2c_w1_wait", dwait, 4'b1010);
    chk("c2c_w1_store", ramstore, 32'hD00D_0002);
    tick(); dREN = '0; ccwrite = '0; ramstate = FREE; #1;
    chk("c2c_end_wen", ramWEN, 1'b0);
    chk("c2c_end_ccwait", ccwait, 4'h0);
    chk("c2c_end_wait", dwait, 4'hF);

    // owner 1 writes with intent: invalidate others, then two writes
    tick(); dWEN = 4'b0010; daddr[1] = 32'h200; dstore[1] = 32'hBEEF_0001; ccwrite = 4'b0010; #1;
    tick();
    chk("wr_arb_ccwait", ccwait, 4'hF);
    tick();
    chk("wr_snp_inv", ccinv, 4'b1101);
    chk("wr_snp_addr3", ccsnoopaddr[3], 32'h200);
    chk("wr_snp_ccwait", ccwait, 4'b1101);
    tick(); ramstate = ACCESS; #1;
    chk("wr_mem_wen", ramWEN, 1'b1);
    chk("wr_mem_ren", ramREN, 1'b0);
    chk("wr_mem_addr", ramaddr, 32'h200);
    chk("wr_mem_store0", ramstore, 32'hBEEF_0001);
    chk("wr_mem_wait", dwait, 4'b1101);
    chk("wr_mem_inv", ccinv, 4'h0);
    tick(); dstore[1] = 32'hBEEF_0002; #1;
    chk("wr_mem_store1", ramstore, 32'hBEEF_0002);
    chk("wr_mem_wait1", dwait, 4'b1101);
    tick(); dWEN = '0; ccwrite = '0; ramstate = FREE; #1;
    chk("wr_end_wen", ramWEN, 1'b0);

    // stuck cctrans: timeout then MEM
    tick(); dREN = 4'b0001; daddr[0] = 32'h500; cctrans = 4'b0010;
    ramstate = ACCESS; ramload = 32'h99; #1;
    tick();
    tick();
    n = 0; errcyc = 0;
    while (ccwait === 4'b1110 && n < 40) begin
      n++;
      if (snoop_err) errcyc = n;
      tick();
    end
    chk("to_snoop_cycles", n, 16);
    chk("to_err_cycle", errcyc, 16);
    chk("to_mem_ren", ramREN, 1'b1);
    chk("to_mem_addr", ramaddr, 32'h500);
    chk("to_mem_load", dload[0], 32'h99);
    chk("to_mem_wait", dwait, 4'b1110);
    chk("to_err_clear", snoop_err, 1'b0);
    tick();
    chk("to_mem_w1_wait", dwait, 4'b1110);
    tick(); dREN = '0; cctrans = '0; ramstate = FREE; #1;
    chk("to_end_wait", dwait, 4'hF);

    // reset mid-transaction
    tick(); dREN = 4'b0100; daddr[2] = 32'h600; ramstate = ACCESS; ramload = 32'h77; #1;
    tick();
    tick();
    chk("rs_snp_ccwait", ccwait, 4'b1011);
    tick();
    chk("rs_w0_addr", ramaddr, 32'h600);
    chk("rs_w0_load", dload[2], 32'h77);
    tick(); ramstate = BUSY; #1;
    chk("rs_w1_ren", ramREN, 1'b1);
    nRST = 1'b0; #1;
    chk("rs_ramREN", ramREN, 1'b0);
    chk("rs_dwait", dwait, 4'hF);
    chk("rs_ccwait", ccwait, 4'h0);
    chk("rs_iwait", iwait, 4'hF);
    chk("rs_ramaddr", ramaddr, 32'h0);
    chk("rs_dload", dload[2], 32'h0);
    tick(); nRST = 1'b1; dREN = 4'b0111; daddr[0] = 32'h700; ramstate = FREE; #1;
    tick();
    tick();
    chk("rs_next_ccwait", ccwait, 4'b1110);
    chk("rs_next_snpaddr", ccsnoopaddr[1], 32'h700);
    tick();
    chk("rs_next_addr", ramaddr, 32'h700);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
